seg_digit_mux: RTL and testbench

Two-digit multiplexed seven-segment display driver that sits directly downstream of the frequency counter. It accepts a BCD tens/units pair on a single-cycle `load` strobe and buffers it until a frame boundary, so both digits always update together. It alternates the shared segment bus between the units and tens digits, blanks the bus during digit switch-over to prevent ghosting, and optionally suppresses a leading zero.

---
 rtl/seg_digit_mux.sv | 182 ++++++++++++++++++
 tb/tb_seg_digit_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_mux.sv
// seg_digit_mux
//   Two-digit multiplexed seven-segment driver. A BCD tens/units pair is
//   captured on a single-cycle load strobe into a pending buffer. The buffer is
//   copied into the display pair only at the frame boundary, which is the
//   entry into SHOW_UNITS, so both digits always change together. The shared
//   segment bus alternates between units and tens, with optional blank
//   dead-time at each switch-over. A tens value of zero can be suppressed.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   load        in   1  capture strobe for ten_count/unit_count
//   ten_count   in   4  BCD tens digit (10-15 shown as a dash)
//   unit_count  in   4  BCD units digit (10-15 shown as a dash)
//   segments    out  7  active-high segments, bit0=a .. bit6=g, registered
//   digit       out  1  digit select, 0 = units, 1 = tens, registered

module seg_digit_mux #(
  parameter int REFRESH_CYCLES     = 64,
  parameter int DEAD_CYCLES        = 2,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  typedef enum logic [1:0] {
    SHOW_UNITS    = 2'd0,
    DEAD_TO_TENS  = 2'd1,
    SHOW_TENS     = 2'd2,
    DEAD_TO_UNITS = 2'd3
  } state_t;

  localparam int MAX_CYCLES = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int PW         = $clog2(MAX_CYCLES + 1);
  localparam bit HAS_DEAD   = (DEAD_CYCLES > 0);

  // Terminal phase counts. The dead-state value is unused when dead time is
  // disabled, so it is clamped to zero to avoid a negative constant.
  localparam logic [PW-1:0] REF_LAST  = PW'(REFRESH_CYCLES - 1);
  localparam logic [PW-1:0] DEAD_LAST = PW'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);

  // BCD to segments (g..a). Codes 10-15 light only the g segment as a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_nxt_s;
  logic [PW-1:0] phase_last_s;
  logic          boundary_s;

  logic [3:0]    pend_t_r;
  logic [3:0]    pend_u_r;
  logic          pend_valid_r;
  logic [3:0]    disp_t_r;
  logic [3:0]    disp_u_r;

  logic [6:0]    seg_nxt_s;
  logic          digit_nxt_s;

  // State and phase counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= SHOW_UNITS;
      phase_r <= {PW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Next-state logic, frame-boundary detection and output selection.
  always_comb begin
    state_nxt_s  = state_r;
    phase_nxt_s  = phase_r + PW'(1'b1);
    phase_last_s = ((state_r == SHOW_UNITS) || (state_r == SHOW_TENS)) ? REF_LAST : DEAD_LAST;
    seg_nxt_s    = 7'h00;
    digit_nxt_s  = 1'b0;

    if (phase_r == phase_last_s) begin
      phase_nxt_s = {PW{1'b0}};
      case (state_r)
        SHOW_UNITS:    state_nxt_s = HAS_DEAD ? DEAD_TO_TENS : SHOW_TENS;
        DEAD_TO_TENS:  state_nxt_s = SHOW_TENS;
        SHOW_TENS:     state_nxt_s = HAS_DEAD ? DEAD_TO_UNITS : SHOW_UNITS;
        DEAD_TO_UNITS: state_nxt_s = SHOW_UNITS;
        default:       state_nxt_s = SHOW_UNITS;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    // SHOW_UNITS always lasts at least one cycle, so entering it is the
    // only way this term can be true.
    boundary_s = (state_nxt_s == SHOW_UNITS) && (state_r != SHOW_UNITS);

    case (state_r)
      SHOW_UNITS: begin
        seg_nxt_s   = decode_bcd(disp_u_r);
        digit_nxt_s = 1'b0;
      end
      DEAD_TO_TENS: begin
        seg_nxt_s   = 7'h00;
        digit_nxt_s = 1'b1;
      end
      SHOW_TENS: begin
        digit_nxt_s = 1'b1;
        if (BLANK_LEADING_ZERO && (disp_t_r == 4'd0)) begin
          seg_nxt_s = 7'h00;
        end else begin
          seg_nxt_s = decode_bcd(disp_t_r);
        end
      end
      DEAD_TO_UNITS: begin
        seg_nxt_s   = 7'h00;
        digit_nxt_s = 1'b0;
      end
      default: begin
        seg_nxt_s   = 7'h00;
        digit_nxt_s = 1'b0;
      end
    endcase
  end

  // Pending buffer and display pair. A load in the boundary cycle is kept
  // pending while the older pending pair is transferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_t_r     <= 4'd0;
      pend_u_r     <= 4'd0;
      pend_valid_r <= 1'b0;
      disp_t_r     <= 4'd0;
      disp_u_r     <= 4'd0;
    end else begin
      if (boundary_s && pend_valid_r) begin
        disp_t_r <= pend_t_r;
        disp_u_r <= pend_u_r;
      end
      if (load) begin
        pend_t_r     <= ten_count;
        pend_u_r     <= unit_count;
        pend_valid_r <= 1'b1;
      end else if (boundary_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      segments <= 7'h00;
      digit    <= 1'b0;
    end else begin
      segments <= seg_nxt_s;
      digit    <= digit_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg_digit_mux.sv
// Testbench for seg_digit_mux. Three instances cover the main configuration
// (REFRESH=4, DEAD=1, blanking on), blanking off, and zero dead time. The
// stimulus pushes hand-computed per-cycle expected outputs into one queue per
// instance. A monitor pops one entry per falling edge and compares it.

module tb_seg_digit_mux;

  typedef struct packed {
    logic [6:0] seg;
    logic       dig;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a, reset_b, reset_c;
  logic       load_a, load_b, load_c;
  logic [3:0] ten_in, unit_in;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dig_a, dig_b, dig_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   idx_a = 0, idx_b = 0, idx_c = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  seg_digit_mux #(.REFRESH_CYCLES(4), .DEAD_CYCLES(1), .BLANK_LEADING_ZERO(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .load(load_a), .ten_count(ten_in), .unit_count(unit_in),
    .segments(seg_a), .digit(dig_a));

  seg_digit_mux #(.REFRESH_CYCLES(4), .DEAD_CYCLES(1), .BLANK_LEADING_ZERO(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .load(load_b), .ten_count(ten_in), .unit_count(unit_in),
    .segments(seg_b), .digit(dig_b));

  seg_digit_mux #(.REFRESH_CYCLES(4), .DEAD_CYCLES(0), .BLANK_LEADING_ZERO(1'b1)) dut_c (
    .clk(clk), .reset(reset_c), .load(load_c), .ten_count(ten_in), .unit_count(unit_in),
    .segments(seg_c), .digit(dig_c));

  task automatic check(input string name, input int idx, input logic [6:0] s, input logic d,
                       input logic [6:0] es, input logic ed);
    n_checks++;
    if ((s === es) && (d === ed)) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got segments=%h digit=%b, expected segments=%h digit=%b",
               name, idx, s, d, es, ed);
    end
  endtask

  task automatic push_item(input int which, input logic [6:0] s, input logic d);
    exp_t e;
    e.seg = s;
    e.dig = d;
    case (which)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  // One frame of REFRESH=4: units, optional dead, tens, optional dead.
  task automatic push_frame(input int which, input logic [6:0] u, input logic [6:0] t,
                            input bit dead);
    for (int i = 0; i < 4; i++) push_item(which, u, 1'b0);
    if (dead) push_item(which, 7'h00, 1'b1);
    for (int i = 0; i < 4; i++) push_item(which, t, 1'b1);
    if (dead) push_item(which, 7'h00, 1'b0);
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drain(input int which, input string name);
    int n;
    n = 0;
    while ((qsize(which) > 0) && (n < 40)) begin
      step();
      n++;
    end
    n_checks++;
    if (qsize(which) == 0) begin
      n_pass++;
    end else begin
      $display("FAIL %s_drain: got %0d entries left, expected 0", name, qsize(which));
    end
  endtask

  // Monitor: one expected entry per falling edge, per instance.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("dut_a", idx_a, seg_a, dig_a, e.seg, e.dig);
      idx_a++;
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("dut_b", idx_b, seg_b, dig_b, e.seg, e.dig);
      idx_b++;
    end
    if (q_c.size() > 0) begin
      e = q_c.pop_front();
      check("dut_c", idx_c, seg_c, dig_c, e.seg, e.dig);
      idx_c++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    load_a  = 1'b0; load_b  = 1'b0; load_c  = 1'b0;
    ten_in  = 4'd0; unit_in = 4'd0;
    step();

    // Instance A: reset state, mid-frame load, overwrite, boundary load, invalid BCD.
    push_item(0, 7'h00, 1'b0);
    push_item(0, 7'h00, 1'b0);
    step();
    step();
    reset_a = 1'b1;
    push_frame(0, 7'h3F, 7'h00, 1'b1);  // reset digits, leading zero blanked
    push_frame(0, 7'h5B, 7'h66, 1'b1);  // 4/2
    push_frame(0, 7'h4F, 7'h6F, 1'b1);  // 9/3, 1/7 never shown
    push_frame(0, 7'h7F, 7'h5B, 1'b1);  // 2/8 while 5/5 stays pending
    push_frame(0, 7'h6D, 7'h6D, 1'b1);  // 5/5
    push_frame(0, 7'h40, 7'h40, 1'b1);  // 12/15 as dashes
    push_frame(0, 7'h40, 7'h40, 1'b1);  // held with nothing pending
    // A load driven at loop index c is captured at rising edge c+1; frame
    // boundaries are at rising edges 10, 20, 30, ...
    for (int c = 0; c < 70; c++) begin
      load_a = 1'b0;
      case (c)
        3:       begin ten_in = 4'd4;  unit_in = 4'd2;  load_a = 1'b1; end
        12:      begin ten_in = 4'd1;  unit_in = 4'd7;  load_a = 1'b1; end
        15:      begin ten_in = 4'd9;  unit_in = 4'd3;  load_a = 1'b1; end
        24:      begin ten_in = 4'd2;  unit_in = 4'd8;  load_a = 1'b1; end
        29:      begin ten_in = 4'd5;  unit_in = 4'd5;  load_a = 1'b1; end
        42:      begin ten_in = 4'd12; unit_in = 4'd15; load_a = 1'b1; end
        default: ;
      endcase
      step();
    end
    load_a = 1'b0;
    drain(0, "dut_a");

    // Instance B: leading-zero blanking disabled.
    push_item(1, 7'h00, 1'b0);
    step();
    reset_b = 1'b1;
    push_frame(1, 7'h3F, 7'h3F, 1'b1);
    push_frame(1, 7'h6D, 7'h3F, 1'b1);  // 0/5
    for (int c = 0; c < 20; c++) begin
      load_b = 1'b0;
      if (c == 2) begin
        ten_in = 4'd0; unit_in = 4'd5; load_b = 1'b1;
      end
      step();
    end
    load_b = 1'b0;
    drain(1, "dut_b");

    // Instance C: no dead time, asynchronous reset in the tens phase.
    push_item(2, 7'h00, 1'b0);
    push_item(2, 7'h00, 1'b0);
    step();
    step();
    reset_c = 1'b1;
    push_frame(2, 7'h3F, 7'h00, 1'b0);
    for (int i = 0; i < 4; i++) push_item(2, 7'h06, 1'b0);  // 6/1 units
    push_item(2, 7'h7D, 1'b1);                              // first tens cycle
    for (int c = 0; c < 13; c++) begin
      load_c = 1'b0;
      case (c)
        1:       begin ten_in = 4'd6; unit_in = 4'd1; load_c = 1'b1; end
        10:      begin ten_in = 4'd3; unit_in = 4'd3; load_c = 1'b1; end
        default: ;
      endcase
      step();
    end
    load_c  = 1'b0;
    reset_c = 1'b0;
    #1;
    check("dut_c_async_reset", 0, seg_c, dig_c, 7'h00, 1'b0);
    push_item(2, 7'h00, 1'b0);
    push_item(2, 7'h00, 1'b0);
    step();
    step();
    reset_c = 1'b1;
    push_frame(2, 7'h3F, 7'h00, 1'b0);  // pending 3/3 lost by reset
    push_frame(2, 7'h3F, 7'h00, 1'b0);
    for (int c = 0; c < 16; c++) step();
    drain(2, "dut_c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
